led_cook_animator: RTL and testbench

Downstream consumer of the cook-mode speed selector's `compare_num` output. It drives the 16-LED bar that shows microwave activity: a rotating 4-LED bar while cooking, a frozen bar while paused, and an 8-step blink when cooking completes. The animation step rate comes from a free-running prescaler whose terminal bit index is `compare_num`, so low, normal and high power animate at slow, medium and fast rates.

---
 rtl/led_cook_animator.sv | 151 +++++++++++++++
 tb/tb_led_cook_animator.sv | 285 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/led_cook_animator.sv
// LED bar animator: rotating bar while cooking, frozen on pause, 8-step blink on done.
// Optional macro LED_BOUNCE_EN makes the bar bounce end to end instead of rotating.
module led_cook_animator #(
  parameter int CNT_W = 22
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [4:0]  compare_num,
  input  logic        run,
  input  logic        done_pulse,
  output logic [15:0] led,
  output logic        flashing
);

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    HOLD,
    DONE
  } state_t;

  state_t             state, state_n;
  logic [CNT_W-1:0]   cnt, cnt_n, mask;
  logic [4:0]         n;
  logic               tick, cnt_clr;
  logic [15:0]        pat, pat_n, led_n, adv_pat;
  logic [2:0]         blink, blink_n;
  logic               flash_n;

  // Out-of-range or unknown indices fall back to normal power.
  always_comb begin
    n = 5'd20;
    unique case (1'b1)
      (compare_num == 5'd19): n = 5'd19;
      (compare_num == 5'd21): n = 5'd21;
      default:                n = 5'd20;
    endcase
  end

  always_comb begin
    mask = ~({CNT_W{1'b1}} << (n + 5'd1));
    tick = &(cnt | ~mask);
  end

`ifdef LED_BOUNCE_EN
  logic dir, dir_n, adv_dir;

  // dir: 0 = moving left, 1 = moving right
  always_comb begin
    if (!dir) begin
      adv_pat = {pat[14:0], 1'b0};
      adv_dir = (adv_pat == 16'hF000);
    end else begin
      adv_pat = {1'b0, pat[15:1]};
      adv_dir = (adv_pat != 16'h000F);
    end
  end

  always_comb begin
    dir_n = dir;
    if (state == IDLE && run)
      dir_n = 1'b0;
    else if (state == RUN && !done_pulse && tick)
      dir_n = adv_dir;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) dir <= 1'b0;
    else        dir <= dir_n;
  end
`else
  always_comb adv_pat = {pat[14:0], pat[15]};
`endif

  always_comb begin
    state_n = state;
    pat_n   = pat;
    led_n   = led;
    blink_n = blink;
    cnt_clr = 1'b0;
    case (state)
      IDLE: begin
        led_n = 16'h0000;
        if (run) begin
          state_n = RUN;
          pat_n   = 16'h000F;
          led_n   = 16'h000F;
          cnt_clr = 1'b1;
        end
      end
      RUN: begin
        if (done_pulse) begin
          state_n = DONE;
          led_n   = 16'hFFFF;
          blink_n = 3'd0;
          cnt_clr = 1'b1;
        end else begin
          if (tick) pat_n = adv_pat;
          led_n = pat_n;
          if (!run) state_n = HOLD;
        end
      end
      HOLD: begin
        led_n = pat;
        if (done_pulse) begin
          state_n = DONE;
          led_n   = 16'hFFFF;
          blink_n = 3'd0;
          cnt_clr = 1'b1;
        end else if (run) begin
          state_n = RUN;
        end
      end
      DONE: begin
        if (tick) begin
          blink_n = blink + 3'd1;
          led_n   = ~led;
          if (blink == 3'd7) begin
            state_n = IDLE;
            led_n   = 16'h0000;
          end
        end
      end
      default: begin
        state_n = IDLE;
        led_n   = 16'h0000;
      end
    endcase
    flash_n = (state_n == DONE);
    cnt_n   = cnt_clr ? '0 : cnt + 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      cnt      <= '0;
      pat      <= 16'h000F;
      led      <= 16'h0000;
      blink    <= 3'd0;
      flashing <= 1'b0;
    end else begin
      state    <= state_n;
      cnt      <= cnt_n;
      pat      <= pat_n;
      led      <= led_n;
      blink    <= blink_n;
      flashing <= flash_n;
    end
  end

endmodule

// File: tb/tb_led_cook_animator.sv
// Scoreboard bench for led_cook_animator; prescaler is preset near a tick
// so that multi-million-cycle periods collapse to a few cycles.
module tb_led_cook_animator;

  localparam int CNT_W = 22;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [4:0]  compare_num = 5'd20;
  logic        run = 1'b0;
  logic        done_pulse = 1'b0;
  logic [15:0] led;
  logic        flashing;

  int tests = 0;
  int fails = 0;

  typedef struct {
    logic [15:0] led;
    logic        fl;
  } exp_t;
  exp_t q[$];

  int              ms;
  logic [15:0]     mpat, mled;
  logic            mfl, mdir, mclr;
  int              mblink;
  longint unsigned mcnt;

  always #5 clk = ~clk;

  led_cook_animator #(.CNT_W(CNT_W)) dut (
    .clk(clk),
    .rst_n(rst_n),
    .compare_num(compare_num),
    .run(run),
    .done_pulse(done_pulse),
    .led(led),
    .flashing(flashing)
  );

  function automatic int eff_n(logic [4:0] c);
    if (c === 5'd19) return 19;
    if (c === 5'd21) return 21;
    return 20;
  endfunction

  function automatic longint unsigned tmask(int nn);
    return (64'd2 << nn) - 64'd1;
  endfunction

  task automatic model_reset();
    ms = 0; mpat = 16'h000F; mled = 16'h0; mfl = 1'b0;
    mblink = 0; mdir = 1'b0; mcnt = 0;
  endtask

  task automatic advance();
`ifdef LED_BOUNCE_EN
    if (!mdir) begin
      mpat = 16'(32'(mpat) * 2);
      if (mpat == 16'hF000) mdir = 1'b1;
    end else begin
      mpat = mpat / 16'd2;
      if (mpat == 16'h000F) mdir = 1'b0;
    end
`else
    mpat = 16'((32'(mpat) * 2) % 32'h10000 + 32'(mpat) / 32'h8000);
`endif
  endtask

  task automatic enter_done();
    ms = 3; mled = 16'hFFFF; mblink = 0; mclr = 1'b1;
  endtask

  // 0 idle, 1 run, 2 hold, 3 done
  task automatic model_step();
    longint unsigned m;
    bit tk;
    exp_t e;
    if (!rst_n) begin
      model_reset();
      return;
    end
    m = tmask(eff_n(compare_num));
    tk = ((mcnt & m) == m);
    mclr = 1'b0;
    case (ms)
      0: begin
        mled = 16'h0;
        if (run) begin
          ms = 1; mpat = 16'h000F; mdir = 1'b0; mclr = 1'b1; mled = mpat;
        end
      end
      1: begin
        if (done_pulse) enter_done();
        else begin
          if (tk) advance();
          mled = mpat;
          if (!run) ms = 2;
        end
      end
      2: begin
        mled = mpat;
        if (done_pulse) enter_done();
        else if (run) ms = 1;
      end
      default: begin
        if (tk) begin
          if (mblink == 7) begin
            ms = 0; mled = 16'h0; mblink = 0;
          end else begin
            mled = ~mled; mblink++;
          end
        end
      end
    endcase
    mfl = (ms == 3);
    mcnt = mclr ? 64'd0 : (mcnt + 64'd1) % (64'd1 << CNT_W);
    e.led = mled;
    e.fl = mfl;
    q.push_back(e);
  endtask

  initial begin
    model_reset();
    forever begin
      @(posedge clk);
      model_step();
    end
  end

  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (rst_n && q.size() > 0) begin
        e = q.pop_front();
        tests++;
        if (led !== e.led || flashing !== e.fl) begin
          fails++;
          $display("FAIL scoreboard t=%0t led=%h flashing=%b expected led=%h flashing=%b",
                   $time, led, flashing, e.led, e.fl);
        end
      end
    end
  end

  task automatic chk(string name, logic [15:0] got, logic [15:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s got=%h expected=%h", name, got, exp);
    end
  endtask

  task automatic cyc(int k);
    repeat (k) @(negedge clk);
  endtask

  task automatic deposit(longint unsigned v);
    logic [CNT_W-1:0] dv;
    dv = CNT_W'(v);
    force dut.cnt = dv;
    mcnt = v;
    #1;
    release dut.cnt;
  endtask

  task automatic near_tick(int k);
    deposit(tmask(eff_n(compare_num)) - longint'(k));
  endtask

  initial begin
    logic [4:0] cn;
    @(negedge clk);
    cyc(2);
    chk("reset_led", led, 16'h0000);
    chk("reset_flashing", {15'd0, flashing}, 16'h0000);
    rst_n = 1'b1;
    cyc(3);

    compare_num = 5'd19;
    run = 1'b1;
    cyc(1);
    chk("run_entry", led, 16'h000F);
    near_tick(3); cyc(5);
    chk("first_tick", led, 16'h001E);
    near_tick(3); cyc(5);
    chk("second_tick", led, 16'h003C);
    repeat (11) begin
      near_tick(2); cyc(4);
    end
`ifdef LED_BOUNCE_EN
    chk("tick13", led, 16'h7800);
`else
    chk("tick13", led, 16'hE001);
`endif

    run = 1'b0;
    cyc(40);
    near_tick(1); cyc(10);
`ifdef LED_BOUNCE_EN
    chk("hold_frozen", led, 16'h7800);
`else
    chk("hold_frozen", led, 16'hE001);
`endif
    run = 1'b1;
    near_tick(2); cyc(4);
`ifdef LED_BOUNCE_EN
    chk("resume", led, 16'h3C00);
`else
    chk("resume", led, 16'hC003);
`endif

    run = 1'b0;
    done_pulse = 1'b1;
    near_tick(0);
    cyc(1);
    done_pulse = 1'b0;
    chk("done_entry", led, 16'hFFFF);
    chk("done_flashing", {15'd0, flashing}, 16'h0001);
    repeat (8) begin
      near_tick(2); cyc(4);
    end
    chk("done_exit_led", led, 16'h0000);
    chk("done_exit_flashing", {15'd0, flashing}, 16'h0000);
    done_pulse = 1'b1; cyc(1); done_pulse = 1'b0; cyc(3);
    chk("idle_ignores_done", led, 16'h0000);

    compare_num = 5'bzzzzz;
    run = 1'b1;
    cyc(2);
    chk("z_entry", led, 16'h000F);
    deposit(tmask(19)); cyc(3);
    chk("z_no_n19_tick", led, 16'h000F);
    near_tick(2); cyc(4);
    chk("z_n20_tick", led, 16'h001E);
    compare_num = 5'd3;
    deposit(tmask(19)); cyc(3);
    chk("cn3_no_n19_tick", led, 16'h001E);
    near_tick(2); cyc(4);
    chk("cn3_n20_tick", led, 16'h003C);

    repeat (200) begin
      case ($urandom_range(0, 4))
        0: cn = 5'd19;
        1: cn = 5'd20;
        2: cn = 5'd21;
        3: cn = 5'd3;
        default: cn = 5'($urandom);
      endcase
      compare_num = cn;
      run = ($urandom_range(0, 3) != 0);
      if ($urandom_range(0, 7) == 0) done_pulse = 1'b1;
      if ($urandom_range(0, 1) == 0) near_tick($urandom_range(0, 3));
      cyc(1);
      done_pulse = 1'b0;
      cyc($urandom_range(0, 8));
    end

    compare_num = 5'd20;
    run = 1'b1;
    cyc(3);
    done_pulse = 1'b1; cyc(1); done_pulse = 1'b0;
    near_tick(1); cyc(4);
    chk("pre_reset_flashing", {15'd0, flashing}, 16'h0001);
    #2;
    rst_n = 1'b0;
    #1;
    chk("async_reset_led", led, 16'h0000);
    chk("async_reset_flashing", {15'd0, flashing}, 16'h0000);
    model_reset();
    q.delete();
    cyc(2);
    rst_n = 1'b1;
    cyc(1);
    chk("restart", led, 16'h000F);
    cyc(5);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
